// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the EX-stage multiply/divide sequencer: opcode
// encodings, FSM state encoding and iteration constants.
package mdu_ctrl_pkg;

    localparam int unsigned OP_W     = 8;
    localparam int unsigned DIV_ITER = 32;
    localparam int unsigned CNT_W    = 5;

    localparam logic [OP_W-1:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [OP_W-1:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [OP_W-1:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [OP_W-1:0] EXE_DIVU_OP  = 8'b0001_1011;
    localparam logic [OP_W-1:0] EXE_ADDU_OP  = 8'b0010_0001;

    typedef enum logic [1:0] {
        MDU_IDLE   = 2'd0,
        MDU_MUL    = 2'd1,
        MDU_DIV_ON = 2'd2,
        MDU_DONE   = 2'd3
    } mdu_state_e;

endpackage

// File: rtl/mdu_ctrl_div.sv
// Radix-2 restoring divider datapath on unsigned magnitudes: one
// quotient bit per enabled cycle, remainder/quotient held in shift registers.
module div_radix2_core #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_nxt_c,
    output logic [WIDTH-1:0] quo_nxt_c
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;

    // Borrow out of the trial subtraction decides the quotient bit.
    always_comb begin
        partial   = {rem_q, quo_q[WIDTH-1]};
        diff      = partial - {1'b0, dvs_q};
        rem_nxt_c = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_nxt_c = {quo_q[WIDTH-2:0], ~diff[WIDTH]};

        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
        end else if (en) begin
            rem_d = rem_nxt_c;
            quo_d = quo_nxt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer: captures MULT/MULTU/DIV/DIVU operands,
// stalls the pipeline while busy and writes HI/LO for one cycle on completion.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned MUL_LAT = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [OP_W-1:0]    alucontrol_e,
    input  logic               valid_e,
    input  logic               flush_e,
    input  logic [WIDTH-1:0]   srca_e,
    input  logic [WIDTH-1:0]   srcb_e,
    output logic               stall_e,
    output logic               busy,
    output logic               hilo_we,
    output logic [2*WIDTH-1:0] hilo_out
);

    mdu_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   hilo_q, hilo_d;

    logic                 is_mul, is_div, is_signed, start;
    logic                 div_load, div_en;
    logic [WIDTH-1:0]     in_mag_a, in_mag_b;
    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [2*WIDTH-1:0]   prod, mul_res;
    logic [WIDTH-1:0]     rem_nxt, quo_nxt, rem_fix, quo_fix;

    div_radix2_core #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .load      (div_load),
        .en        (div_en),
        .dividend  (in_mag_a),
        .divisor   (in_mag_b),
        .rem_nxt_c (rem_nxt),
        .quo_nxt_c (quo_nxt)
    );

    // Magnitude datapath and sign fix-up for both multiply and divide.
    always_comb begin
        is_mul    = (alucontrol_e == EXE_MULT_OP) || (alucontrol_e == EXE_MULTU_OP);
        is_div    = (alucontrol_e == EXE_DIV_OP)  || (alucontrol_e == EXE_DIVU_OP);
        is_signed = (alucontrol_e == EXE_MULT_OP) || (alucontrol_e == EXE_DIV_OP);
        start     = valid_e & ~flush_e & (state_q == MDU_IDLE) & (is_mul | is_div);

        in_mag_a = (is_signed && srca_e[WIDTH-1]) ? -srca_e : srca_e;
        in_mag_b = (is_signed && srcb_e[WIDTH-1]) ? -srcb_e : srcb_e;
        mag_a    = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
        mag_b    = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;

        prod    = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
        mul_res = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod : prod;
        quo_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_nxt : quo_nxt;
        rem_fix = (sgn_q && a_q[WIDTH-1]) ? -rem_nxt : rem_nxt;
    end

    // Next-state logic; a flush overrides everything and drops the result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        sgn_d    = sgn_q;
        hilo_d   = hilo_q;
        div_load = 1'b0;
        div_en   = 1'b0;

        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    a_d   = srca_e;
                    b_d   = srcb_e;
                    sgn_d = is_signed;
                    cnt_d = '0;
                    if (is_mul) begin
                        state_d = MDU_MUL;
                    end else if (srcb_e != '0) begin
                        state_d  = MDU_DIV_ON;
                        div_load = 1'b1;
                    end else begin
                        state_d = MDU_DONE;
                        hilo_d  = {srca_e, {WIDTH{1'b1}}};
                    end
                end
            end
            MDU_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
                    hilo_d  = mul_res;
                    cnt_d   = '0;
                    state_d = MDU_DONE;
                end
            end
            MDU_DIV_ON: begin
                div_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
                    hilo_d  = {rem_fix, quo_fix};
                    cnt_d   = '0;
                    state_d = MDU_DONE;
                end
            end
            MDU_DONE: begin
                state_d = MDU_IDLE;
            end
        endcase

        if (flush_e) begin
            state_d  = MDU_IDLE;
            cnt_d    = '0;
            hilo_d   = hilo_q;
            div_load = 1'b0;
            div_en   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hilo_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            hilo_q  <= hilo_d;
        end
    end

    // Pipeline-facing controls react to flush/reset within the same cycle.
    assign stall_e  = resetn & ~flush_e &
                      (start | (state_q == MDU_MUL) | (state_q == MDU_DIV_ON));
    assign busy     = (state_q != MDU_IDLE);
    assign hilo_we  = resetn & ~flush_e & (state_q == MDU_DONE);
    assign hilo_out = hilo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases with literal results plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int unsigned TB_MUL_LAT = 1;

    logic        clk;
    logic        resetn;
    logic [7:0]  alucontrol_e;
    logic        valid_e;
    logic        flush_e;
    logic [31:0] srca_e;
    logic [31:0] srcb_e;
    logic        stall_e;
    logic        busy;
    logic        hilo_we;
    logic [63:0] hilo_out;

    int errors = 0;
    int checks = 0;

    mdu_ctrl #(.WIDTH(32), .MUL_LAT(TB_MUL_LAT)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .alucontrol_e (alucontrol_e),
        .valid_e      (valid_e),
        .flush_e      (flush_e),
        .srca_e       (srca_e),
        .srcb_e       (srcb_e),
        .stall_e      (stall_e),
        .busy         (busy),
        .hilo_we      (hilo_we),
        .hilo_out     (hilo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit is_mdu(input logic [7:0] op);
        return op == EXE_MULT_OP || op == EXE_MULTU_OP || op == EXE_DIV_OP || op == EXE_DIVU_OP;
    endfunction

    // Architectural result of an MDU instruction, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_result(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        if (op == EXE_MULT_OP) begin
            r = 64'(sa * sb);
        end else if (op == EXE_MULTU_OP) begin
            r = 64'(ua * ub);
        end else if (b == 32'h0) begin
            r = {a, 32'hFFFF_FFFF};
        end else if (op == EXE_DIV_OP) begin
            sq = sa / sb;
            sr = sa % sb;
            r  = {sr[31:0], sq[31:0]};
        end else begin
            r = {32'(ua % ub), 32'(ua / ub)};
        end
        return r;
    endfunction

    function automatic int ref_latency(input logic [7:0] op, input logic [31:0] b);
        if (op == EXE_MULT_OP || op == EXE_MULTU_OP) return int'(TB_MUL_LAT) + 1;
        if (b == 32'h0) return 1;
        return 33;
    endfunction

    // Model: an accepted instruction completes at a known cycle unless flushed/reset.
    int          cyc = 0;
    bit          m_pend = 1'b0;
    int          m_done = 0;
    logic [63:0] m_res = '0;
    logic [63:0] m_hilo = '0;
    bit          check_en = 1'b0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_pend = 1'b0;
            m_hilo = '0;
        end else if (flush_e) begin
            m_pend = 1'b0;
        end else if (m_pend && cyc == m_done) begin
            m_pend = 1'b0;
        end else if (!m_pend && valid_e && is_mdu(alucontrol_e)) begin
            m_pend = 1'b1;
            m_done = cyc + ref_latency(alucontrol_e, srcb_e);
            m_res  = ref_result(alucontrol_e, srca_e, srcb_e);
        end
        if (m_pend && cyc + 1 == m_done) m_hilo = m_res;
        cyc++;
    end

    always @(negedge clk) begin
        if (check_en) begin
            bit m_start;
            m_start = resetn && !flush_e && valid_e && !m_pend && is_mdu(alucontrol_e);
            chk("stall_e", stall_e, resetn && !flush_e && (m_start || (m_pend && cyc < m_done)));
            chk("busy", busy, m_pend);
            chk("hilo_we", hilo_we, resetn && !flush_e && m_pend && cyc == m_done);
            chk("hilo_out", hilo_out, m_hilo);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction, hold it in EX while stalled, and pin its outcome.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int exp_stall, input string nm);
        int          stalls = 0;
        int          n = 0;
        bit          seen = 1'b0;
        logic [63:0] got = '0;
        chk({"model_", nm}, ref_result(op, a, b), exp);
        valid_e = 1'b1;
        alucontrol_e = op;
        srca_e = a;
        srcb_e = b;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (stall_e) stalls++;
            if (hilo_we) begin
                seen = 1'b1;
                got  = hilo_out;
            end
            tick();
            n++;
            srca_e = $urandom;
            srcb_e = $urandom;
        end
        valid_e = 1'b0;
        chk({nm, "_done_seen"}, seen, 1'b1);
        chk({nm, "_hilo"}, got, exp);
        chk({nm, "_stall_cycles"}, 64'(stalls), 64'(exp_stall));
        @(negedge clk);
        chk({nm, "_we_width"}, hilo_we, 1'b0);
        tick();
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit we_seen;
        resetn = 1'b0;
        valid_e = 1'b0;
        flush_e = 1'b0;
        alucontrol_e = EXE_ADDU_OP;
        srca_e = '0;
        srcb_e = '0;
        tick();
        tick();
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_hilo", hilo_out, 64'h0);
        resetn = 1'b1;
        tick();

        run_op(EXE_MULT_OP, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 2, "mult_neg");
        run_op(EXE_DIVU_OP, 32'd100, 32'd7, {32'h2, 32'hE}, 33, "divu_100_7");
        run_op(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "div_m7_2");
        run_op(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33, "div_ovf");
        run_op(EXE_DIV_OP, 32'h0000_1234, 32'h0, {32'h1234, 32'hFFFF_FFFF}, 1, "div_by0");
        run_op(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 2, "multu_max");

        // Flush in the middle of a divide: nothing may be written back.
        valid_e = 1'b1;
        alucontrol_e = EXE_DIVU_OP;
        srca_e = 32'd1000;
        srcb_e = 32'd3;
        repeat (11) tick();
        flush_e = 1'b1;
        tick();
        flush_e = 1'b0;
        valid_e = 1'b0;
        @(negedge clk);
        chk("flush_idle", busy, 1'b0);
        we_seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (hilo_we) we_seen = 1'b1;
        end
        chk("flush_no_we", we_seen, 1'b0);
        tick();
        run_op(EXE_DIVU_OP, 32'd9, 32'd3, {32'h0, 32'h3}, 33, "divu_after_flush");

        // Synchronous reset in the middle of a divide.
        valid_e = 1'b1;
        alucontrol_e = EXE_DIV_OP;
        srca_e = 32'd77;
        srcb_e = 32'd5;
        repeat (6) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        valid_e = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_stall", stall_e, 1'b0);
        chk("rst_we", hilo_we, 1'b0);
        chk("rst_hilo", hilo_out, 64'h0);
        tick();

        // Non-MDU instruction never stalls.
        valid_e = 1'b1;
        alucontrol_e = EXE_ADDU_OP;
        repeat (5) begin
            @(negedge clk);
            chk("addu_no_stall", stall_e, 1'b0);
            tick();
        end

        // Randomized traffic, checked every cycle against the model.
        for (int i = 0; i < 4000; i++) begin
            valid_e = ($urandom_range(0, 99) < 80);
            case ($urandom_range(0, 5))
                0: alucontrol_e = EXE_MULT_OP;
                1: alucontrol_e = EXE_MULTU_OP;
                2: alucontrol_e = EXE_DIV_OP;
                3: alucontrol_e = EXE_DIVU_OP;
                4: alucontrol_e = EXE_ADDU_OP;
                default: alucontrol_e = 8'($urandom);
            endcase
            srca_e  = pick_operand();
            srcb_e  = pick_operand();
            flush_e = ($urandom_range(0, 63) == 0);
            resetn  = ($urandom_range(0, 499) != 0);
            tick();
        end
        resetn  = 1'b1;
        flush_e = 1'b0;
        valid_e = 1'b0;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
